adc_ad4003_capture: RTL and testbench
=====================================

Name: adc_ad4003_capture

Overview:
- Parametrised successor to the per-module AD4003 shift-register array.
- Captures N single-ended SDO lanes with one shared frame FSM; lanes 2k and 2k+1 are cha/chb of ADC module k.
- Adds frame-length checking, per-channel enable masking, optional power-of-two decimation (accumulate), a registered `data_valid` strobe, a sample counter and sticky error flags.
- Sits between the top-level IBUFDS stage (kept outside this block) and the DMA/packer.

Parameters:
- ADC_CHANNELS, 8, number of SDO lanes; even, 2..48.
- ADC_DATA_WIDTH, 18, bits per conversion; MSB first, two's complement.
- DECIM_LOG2, 0, log2 of the decimation factor D; range 0..6; 0 = no decimation.
- OUT_WIDTH, ADC_DATA_WIDTH+DECIM_LOG2, output word width per channel; derived, do not override.
- CNT_WIDTH, 32, width of the sample counter.

Ports:
- adc_read_clk  in  1  capture clock; delayed 80 MHz read clock.
- rst  in  1  synchronous, active-high reset.
- adc_sdo  in  ADC_CHANNELS  SDO lanes after IBUFDS; bit 2k = module k cha, bit 2k+1 = module k chb.
- reader_en_sync  in  1  read window, synchronous to adc_read_clk; high while bits are clocked out.
- chan_en  in  ADC_CHANNELS  per-lane enable; sampled at LATCH.
- clr_err  in  1  clears the sticky error flags.
- adc_data_arr  out  OUT_WIDTH*ADC_CHANNELS  channel c occupies [OUT_WIDTH*c +: OUT_WIDTH].
- data_valid  out  1  one-cycle strobe; adc_data_arr is valid on this cycle.
- sample_cnt  out  CNT_WIDTH  number of data_valid strobes since reset; wraps.
- short_frame_err  out  1  sticky; a window closed before ADC_DATA_WIDTH bits.
- long_frame_err  out  1  sticky; a window stayed high past ADC_DATA_WIDTH bits.

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - FSM to IDLE, bit counter, all shift registers, accumulators and decimation counter;
  - adc_data_arr=0, data_valid=0, sample_cnt=0, both error flags=0.
- Reset mid-frame aborts the frame; no partial data is emitted.
- FSM states:
  - IDLE: on reader_en_sync=1, shift bit 0 of every lane into its SR LSB (SR <= {SR[W-2:0], sdo}), set bit_cnt=1, go to SHIFT.
  - SHIFT: while reader_en_sync=1, shift and increment bit_cnt.
    - When bit_cnt reaches ADC_DATA_WIDTH-1 and a shift occurs, go to LATCH.
    - If reader_en_sync=0 in SHIFT: set short_frame_err, discard the SR contents, go to IDLE.
  - LATCH (one cycle): for every lane, sign-extend SR to OUT_WIDTH.
    - If chan_en[c]=0, the value used is 0.
    - DECIM_LOG2=0: register the value to adc_data_arr; data_valid=1 on the following cycle.
    - DECIM_LOG2>0: acc[c] += value. On the D-th sample, adc_data_arr = acc + value (the full sum, no shift); then acc cleared, data_valid=1, decim_cnt wraps to 0.
    - Go to WAIT.
  - WAIT: if reader_en_sync=1 on entry or later, set long_frame_err. Go to IDLE when reader_en_sync=0.
- Latency: data_valid is asserted 2 cycles after the cycle sampling the last (LSB) bit.
- adc_data_arr holds its value between strobes.
- data_valid is never high on two consecutive cycles.
- sample_cnt increments on each data_valid and wraps from 2^CNT_WIDTH-1 to 0.
- Accumulator width is OUT_WIDTH, so the sum cannot overflow: D*(-2^(W-1)) fits exactly.
- chan_en changes take effect at the next LATCH. A mid-decimation change affects only the remaining samples of the current group.
- clr_err clears both flags. If clr_err and an error event coincide, the error wins (flag stays 1).
- No back-pressure; the consumer must accept data on data_valid.

Test Plan:
- Reset then a single frame, DECIM_LOG2=0, W=18, lane0 SDO=0x1FFFF, lane1=0x20000 → lane0 output 0x1FFFF, lane1 output 0x20000 (sign-extended −131072), data_valid one cycle, sample_cnt=1.
- Window held for only 10 bits → short_frame_err=1, no data_valid, previous adc_data_arr unchanged. clr_err pulse → flag=0.
- Window held for 20 cycles → data_valid once with correct data, long_frame_err=1. Next good frame → correct data, flag stays 1 until clr_err.
- DECIM_LOG2=2, lane0 frames 100, −50, 7, 3 → one data_valid after the 4th frame, output 60 (20-bit). Frames 1–3 produce no strobe.
- chan_en=8'hFE, all lanes 0x00123 → lane0 output 0, lanes 1–7 output 0x00123.
- Assert rst at bit 9 of a frame, then send a full frame of 0x2AAAA → no spurious strobe; output 0x2AAAA sign-extended (−87382), sample_cnt=1.

Source files
------------

// File: rtl/adc_ad4003_capture.sv
// adc_ad4003_capture: captures N single-ended AD4003 SDO lanes with one shared frame FSM.
// It checks frame length, masks disabled channels, can decimate by summing D frames, and counts output samples.
module adc_ad4003_capture #(
   parameter int unsigned ADC_CHANNELS   = 8,
   parameter int unsigned ADC_DATA_WIDTH = 18,
   parameter int unsigned DECIM_LOG2     = 0,
   parameter int unsigned OUT_WIDTH      = ADC_DATA_WIDTH + DECIM_LOG2,
   parameter int unsigned CNT_WIDTH      = 32
) (
   input  logic                              adc_read_clk,
   input  logic                              rst,
   input  logic [ADC_CHANNELS-1:0]           adc_sdo,
   input  logic                              reader_en_sync,
   input  logic [ADC_CHANNELS-1:0]           chan_en,
   input  logic                              clr_err,
   output logic [OUT_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
   output logic                              data_valid,
   output logic [CNT_WIDTH-1:0]              sample_cnt,
   output logic                              short_frame_err,
   output logic                              long_frame_err
);

   localparam int unsigned BCW        = $clog2(ADC_DATA_WIDTH + 1);
   localparam int unsigned DCW        = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int unsigned DECIM_LAST = (1 << DECIM_LOG2) - 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_WAIT} state_t;

   state_t                            r_state;
   logic [BCW-1:0]                    r_bit_cnt;
   logic [DCW-1:0]                    r_decim_cnt;
   logic [ADC_DATA_WIDTH-1:0]         r_sr  [ADC_CHANNELS];
   logic [OUT_WIDTH-1:0]              r_acc [ADC_CHANNELS];
   logic [OUT_WIDTH*ADC_CHANNELS-1:0] r_data;
   logic                              r_valid;
   logic [CNT_WIDTH-1:0]              r_sample_cnt;
   logic                              r_short_err;
   logic                              r_long_err;

   logic [OUT_WIDTH-1:0]              w_sum [ADC_CHANNELS];
   logic                              w_group_done;

   // Running sum per lane: the sign-extended frame is added only if the lane is enabled.
   always_comb begin
      for (int c = 0; c < ADC_CHANNELS; c++) begin
         w_sum[c] = r_acc[c];
         if (chan_en[c]) begin
            w_sum[c] = r_acc[c] + OUT_WIDTH'($signed(r_sr[c]));
         end
      end
   end

   // With no decimation the counter stays at 0, so every frame completes a group.
   assign w_group_done = (r_decim_cnt == DCW'(DECIM_LAST));

   always_ff @(posedge adc_read_clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= '0;
         r_decim_cnt  <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_sample_cnt <= '0;
         r_short_err  <= 1'b0;
         r_long_err   <= 1'b0;
         for (int c = 0; c < ADC_CHANNELS; c++) begin
            r_sr[c]  <= '0;
            r_acc[c] <= '0;
         end
      end else begin
         r_valid <= 1'b0;
         // Clear comes first, so an error event in the same cycle still sets its flag.
         if (clr_err) begin
            r_short_err <= 1'b0;
            r_long_err  <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (reader_en_sync) begin
                  for (int c = 0; c < ADC_CHANNELS; c++) begin
                     r_sr[c] <= {r_sr[c][ADC_DATA_WIDTH-2:0], adc_sdo[c]};
                  end
                  r_bit_cnt <= BCW'(1);
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (reader_en_sync) begin
                  for (int c = 0; c < ADC_CHANNELS; c++) begin
                     r_sr[c] <= {r_sr[c][ADC_DATA_WIDTH-2:0], adc_sdo[c]};
                  end
                  if (r_bit_cnt == BCW'(ADC_DATA_WIDTH - 1)) begin
                     r_bit_cnt <= '0;
                     r_state   <= ST_LATCH;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                  end
               end else begin
                  r_short_err <= 1'b1;
                  r_bit_cnt   <= '0;
                  for (int c = 0; c < ADC_CHANNELS; c++) begin
                     r_sr[c] <= '0;
                  end
                  r_state <= ST_IDLE;
               end
            end
            ST_LATCH: begin
               if (w_group_done) begin
                  for (int c = 0; c < ADC_CHANNELS; c++) begin
                     r_data[OUT_WIDTH*c +: OUT_WIDTH] <= w_sum[c];
                     r_acc[c] <= '0;
                  end
                  r_decim_cnt  <= '0;
                  r_valid      <= 1'b1;
                  r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
               end else begin
                  for (int c = 0; c < ADC_CHANNELS; c++) begin
                     r_acc[c] <= w_sum[c];
                  end
                  r_decim_cnt <= r_decim_cnt + DCW'(1);
               end
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (reader_en_sync) begin
                  r_long_err <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign adc_data_arr    = r_data;
   assign data_valid      = r_valid;
   assign sample_cnt      = r_sample_cnt;
   assign short_frame_err = r_short_err;
   assign long_frame_err  = r_long_err;

endmodule

// File: tb/tb_adc_ad4003_capture.sv
// Scoreboard bench for adc_ad4003_capture: one instance runs without decimation and one with D=4.
// Expected words are queued as frames are sent, and monitors pop them on each data_valid.
module tb_adc_ad4003_capture;

   localparam int unsigned CH  = 8;
   localparam int unsigned W   = 18;
   localparam int unsigned OW2 = 20;

   typedef struct {
      logic [W*CH-1:0] data;
      logic [31:0]     cnt;
   } exp0_t;

   typedef struct {
      logic [OW2*CH-1:0] data;
      logic [31:0]       cnt;
   } exp2_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CH-1:0]     sdo = '0;
   logic              en0 = 1'b0;
   logic              en2 = 1'b0;
   logic [CH-1:0]     chan_en = '1;
   logic              clr_err = 1'b0;

   logic [W*CH-1:0]   data0;
   logic              dv0;
   logic [31:0]       cnt0;
   logic              serr0, lerr0;
   logic [OW2*CH-1:0] data2;
   logic              dv2;
   logic [31:0]       cnt2;
   logic              serr2, lerr2;

   int n_checks = 0;
   int n_errors = 0;

   exp0_t q0[$];
   exp2_t q2[$];
   int unsigned     exp_cnt0 = 0;
   int unsigned     exp_cnt2 = 0;
   logic [W*CH-1:0] last0 = '0;
   logic            prev_dv0 = 1'b0;
   logic            prev_dv2 = 1'b0;

   always #5 clk = ~clk;

   adc_ad4003_capture #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .DECIM_LOG2(0)) dut0 (
      .adc_read_clk(clk), .rst(rst), .adc_sdo(sdo), .reader_en_sync(en0),
      .chan_en(chan_en), .clr_err(clr_err), .adc_data_arr(data0), .data_valid(dv0),
      .sample_cnt(cnt0), .short_frame_err(serr0), .long_frame_err(lerr0));

   adc_ad4003_capture #(.ADC_CHANNELS(CH), .ADC_DATA_WIDTH(W), .DECIM_LOG2(2)) dut2 (
      .adc_read_clk(clk), .rst(rst), .adc_sdo(sdo), .reader_en_sync(en2),
      .chan_en(chan_en), .clr_err(clr_err), .adc_data_arr(data2), .data_valid(dv2),
      .sample_cnt(cnt2), .short_frame_err(serr2), .long_frame_err(lerr2));

   // Monitor for the undecimated instance
   always @(negedge clk) begin
      exp0_t e;
      if (dv0) begin
         n_checks++;
         if (prev_dv0) begin
            n_errors++;
            $display("FAIL dut0_consecutive_valid: data_valid high two cycles in a row");
         end else if (q0.size() == 0) begin
            n_errors++;
            $display("FAIL dut0_unexpected_strobe: data=%h cnt=%0d", data0, cnt0);
         end else begin
            e = q0.pop_front();
            if (data0 !== e.data || cnt0 !== e.cnt) begin
               n_errors++;
               $display("FAIL dut0_sample: got data=%h cnt=%0d expected data=%h cnt=%0d",
                        data0, cnt0, e.data, e.cnt);
            end
         end
      end
      prev_dv0 = dv0;
   end

   // Monitor for the decimating instance
   always @(negedge clk) begin
      exp2_t e;
      if (dv2) begin
         n_checks++;
         if (prev_dv2) begin
            n_errors++;
            $display("FAIL dut2_consecutive_valid: data_valid high two cycles in a row");
         end else if (q2.size() == 0) begin
            n_errors++;
            $display("FAIL dut2_unexpected_strobe: data=%h cnt=%0d", data2, cnt2);
         end else begin
            e = q2.pop_front();
            if (data2 !== e.data || cnt2 !== e.cnt) begin
               n_errors++;
               $display("FAIL dut2_sample: got data=%h cnt=%0d expected data=%h cnt=%0d",
                        data2, cnt2, e.data, e.cnt);
            end
         end
      end
      prev_dv2 = dv2;
   end

   task automatic chk(input string name, input logic [W*CH-1:0] act, input logic [W*CH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W*CH-1:0] mask0(input logic [W*CH-1:0] w, input logic [CH-1:0] m);
      logic [W*CH-1:0] r;
      r = w;
      for (int c = 0; c < CH; c++) if (!m[c]) r[W*c +: W] = '0;
      return r;
   endfunction

   function automatic logic [W*CH-1:0] all_lanes(input logic [W-1:0] v);
      return {CH{v}};
   endfunction

   // Drive nbits cycles of window on the selected instance, MSB first; bits past W are 0.
   task automatic send(input bit sel2, input logic [W*CH-1:0] words, input int nbits,
                       input bit clr_end);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         if (sel2) en2 = 1'b1; else en0 = 1'b1;
         for (int c = 0; c < CH; c++)
            sdo[c] = (i < int'(W)) ? words[W*c + (W-1-i)] : 1'b0;
      end
      @(negedge clk);
      en0 = 1'b0;
      en2 = 1'b0;
      sdo = '0;
      clr_err = clr_end;
      @(negedge clk);
      clr_err = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic push0(input logic [W*CH-1:0] words);
      exp0_t e;
      exp_cnt0++;
      e.data = mask0(words, chan_en);
      e.cnt  = exp_cnt0;
      last0  = e.data;
      q0.push_back(e);
   endtask

   task automatic push2(input logic [OW2*CH-1:0] d);
      exp2_t e;
      exp_cnt2++;
      e.data = d;
      e.cnt  = exp_cnt2;
      q2.push_back(e);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W*CH-1:0]   w;
      logic [OW2*CH-1:0] d2;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_data0", data0, '0);
      chk("reset_cnt0", W*CH'(cnt0), '0);
      chk("reset_flags0", W*CH'({dv0, serr0, lerr0}), '0);
      chk("reset_data2", W*CH'(data2[W*CH-1:0]), '0);

      // Full-scale positive and negative codes on lanes 0 and 1
      w = {18'h15555, 18'h2AAAA, 18'h0ABCD, 18'h12345, 18'h3FFFF, 18'h00001, 18'h20000, 18'h1FFFF};
      push0(w);
      send(1'b0, w, W, 1'b0);

      // Short window: flag, no strobe, output held
      send(1'b0, all_lanes(18'h3C3C3), 10, 1'b0);
      chk("short_err_set", W*CH'(serr0), W*CH'(1));
      chk("short_no_long", W*CH'(lerr0), '0);
      chk("short_data_held", data0, last0);
      pulse_clr();
      chk("short_err_clear", W*CH'(serr0), '0);

      // Clear coinciding with a short-frame error: error wins
      send(1'b0, all_lanes(18'h00F0F), 10, 1'b1);
      chk("short_err_vs_clr", W*CH'(serr0), W*CH'(1));
      pulse_clr();
      chk("short_err_clear2", W*CH'(serr0), '0);

      // Long window: data still emitted, long flag sticky across a good frame
      w = {18'h00007, 18'h3FFF9, 18'h1ABCD, 18'h25432, 18'h00100, 18'h3FF00, 18'h11111, 18'h2EEEE};
      push0(w);
      send(1'b0, w, 20, 1'b0);
      chk("long_err_set", W*CH'(lerr0), W*CH'(1));
      w = {18'h00000, 18'h3FFFF, 18'h00002, 18'h3FFFE, 18'h10000, 18'h30000, 18'h0F0F0, 18'h30F0F};
      push0(w);
      send(1'b0, w, W, 1'b0);
      chk("long_err_sticky", W*CH'(lerr0), W*CH'(1));
      pulse_clr();
      chk("long_err_clear", W*CH'(lerr0), '0);

      // Lane 0 disabled
      chan_en = 8'hFE;
      push0(all_lanes(18'h00123));
      send(1'b0, all_lanes(18'h00123), W, 1'b0);
      chan_en = 8'hFF;

      // Reset at bit 9 of a frame aborts it
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         en0 = 1'b1;
         sdo = (i % 2 == 0) ? '1 : '0;
      end
      @(negedge clk);
      en0 = 1'b0;
      sdo = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt0 = 0;
      exp_cnt2 = 0;
      @(negedge clk);
      chk("midframe_reset_data", data0, '0);
      chk("midframe_reset_cnt", W*CH'(cnt0), '0);
      push0(all_lanes(18'h2AAAA));
      send(1'b0, all_lanes(18'h2AAAA), W, 1'b0);

      // Decimation by 4: lane0 100, -50, 7, 3 sums to 60
      w = '0; w[W-1:0] = 18'd100;   send(1'b1, w, W, 1'b0);
      w = '0; w[W-1:0] = 18'h3FFCE; send(1'b1, w, W, 1'b0);
      w = '0; w[W-1:0] = 18'd7;     send(1'b1, w, W, 1'b0);
      chk("decim_no_early_strobe", W*CH'(cnt2), '0);
      d2 = '0; d2[OW2-1:0] = 20'd60;
      push2(d2);
      w = '0; w[W-1:0] = 18'd3;     send(1'b1, w, W, 1'b0);

      // Most negative code four times fills the 20-bit output exactly
      for (int k = 0; k < 3; k++) send(1'b1, all_lanes(18'h20000), W, 1'b0);
      push2({CH{20'h80000}});
      send(1'b1, all_lanes(18'h20000), W, 1'b0);

      repeat (5) @(negedge clk);
      chk("final_cnt0", W*CH'(cnt0), W*CH'(1));
      chk("final_cnt2", W*CH'(cnt2), W*CH'(2));
      chk("q0_drained", W*CH'(q0.size()), '0);
      chk("q2_drained", W*CH'(q2.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
